// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and queue-entry type for the write-back arbiter
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam int MAX_DEPTH  = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_kill_fifo.sv
// rtl/wb_kill_fifo.sv - multicycle-result FIFO with address-match kill and lookup
module wb_kill_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr_a,
    input  logic [REG_ADDR_W-1:0] chk_addr_b,
    output wb_entry_t             head,
    output logic [CNT_W-1:0]      count,
    output logic                  match_a,
    output logic                  match_b
);
    // Storage is sized for the largest legal depth; slots past DEPTH stay dead.
    wb_entry_t        mem [MAX_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_live;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];
    // An entry entering in the same cycle as a matching pipeline write is born dead.
    assign push_live = push_entry.live && !(kill && push_entry.addr == kill_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                if (kill && mem[i].live && mem[i].addr == kill_addr) mem[i].live <= 1'b0;
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= ptr_next(rd_ptr);
            end
            if (push) begin
                mem[wr_ptr] <= '{live: push_live, addr: push_entry.addr, data: push_entry.data};
                wr_ptr      <= ptr_next(wr_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (mem[i].live && mem[i].addr == chk_addr_a && chk_addr_a != ZERO_REG) match_a = 1'b1;
            if (mem[i].live && mem[i].addr == chk_addr_b && chk_addr_b != ZERO_REG) match_b = 1'b1;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - arbitrates pipeline and multicycle results onto one register-file write port
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0]     mc_data,
    output logic                  mc_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    input  logic [REG_ADDR_W-1:0] chk_addr_a,
    input  logic [REG_ADDR_W-1:0] chk_addr_b,
    output logic                  pending_a,
    output logic                  pending_b,
    output logic [15:0]           stall_cnt
);
    wb_entry_t        head;
    wb_entry_t        push_entry;
    logic [CNT_W-1:0] count;
    logic             wb_sel, q_empty, mc_xfer, bypass, push, head_pop, head_write;
    logic             sel_we;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;

    assign wb_sel   = wb_write && (wb_addr != ZERO_REG);
    assign q_empty  = (count == '0);
    // Readiness uses the pre-pop count, so a full queue never accepts on its drain cycle.
    assign mc_ready = !rst && (count < CNT_W'(DEPTH));
    assign mc_xfer  = mc_valid && mc_ready;
    assign bypass   = q_empty && !wb_sel && mc_xfer;
    assign push     = mc_xfer && !bypass && (mc_addr != ZERO_REG);
    // Dead heads drain even under a pipeline write; live heads wait for a free port.
    assign head_pop   = !q_empty && (!head.live || !wb_sel);
    assign head_write = !q_empty && head.live && !wb_sel;
    assign push_entry = '{live: 1'b1, addr: mc_addr, data: mc_data};

    wb_kill_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (head_pop),
        .kill       (wb_sel),
        .kill_addr  (wb_addr),
        .chk_addr_a (chk_addr_a),
        .chk_addr_b (chk_addr_b),
        .head       (head),
        .count      (count),
        .match_a    (pending_a),
        .match_b    (pending_b)
    );

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = ZERO_REG;
        sel_data = '0;
        if (wb_sel) begin
            sel_we   = 1'b1;
            sel_addr = wb_addr;
            sel_data = wb_data;
        end else if (head_write) begin
            sel_we   = 1'b1;
            sel_addr = head.addr;
            sel_data = head.data;
        end else if (bypass && mc_addr != ZERO_REG) begin
            sel_we   = 1'b1;
            sel_addr = mc_addr;
            sel_data = mc_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_addr   <= ZERO_REG;
            rf_data   <= '0;
            stall_cnt <= '0;
        end else begin
            rf_we   <= sel_we;
            rf_addr <= sel_addr;
            rf_data <= sel_data;
            if (mc_valid && !mc_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the multicycle-result queue depth in entries (legal values 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have inputs wb_write (1), wb_addr (5) and wb_data (32): the pipeline write-back request, which is always accepted and has no backpressure.
REQ-005 The block SHALL have inputs mc_valid (1), mc_addr (5) and mc_data (32), plus output mc_ready (1): the multicycle-unit result handshake.
REQ-006 The block SHALL have outputs rf_we (1), rf_addr (5) and rf_data (32): registered register-file write port.
REQ-007 The block SHALL have inputs chk_addr_a (5) and chk_addr_b (5), plus outputs pending_a (1) and pending_b (1): the hazard query from decode.
REQ-008 The block SHALL have output stall_cnt, 16 bits: saturating count of mc backpressure cycles.

Function
REQ-009 An mc transfer SHALL occur on a posedge where mc_valid=1 and mc_ready=1; mc_ready = (queue count < DEPTH), with no same-cycle pop credit.
REQ-010 Priority per cycle SHALL be: pipeline write (wb_write=1, wb_addr!=0) first; otherwise queue head; otherwise a bypassed mc transfer.
REQ-011 The selected write SHALL appear on rf_we/rf_addr/rf_data exactly 1 cycle after its request edge; rf_we=0 when nothing is selected.
REQ-012 Writes to address 0 SHALL never assert rf_we; an mc transfer with mc_addr=0 is accepted and discarded.
REQ-013 Bypass: when the queue is empty, no pipeline write is pending and an mc transfer occurs, the transfer SHALL go to the rf outputs directly and not be enqueued.
REQ-014 An mc transfer that loses arbitration SHALL be enqueued at the tail; the queue drains in FIFO order, at most one pop per cycle.
REQ-015 WAW kill: a pipeline write to address X SHALL mark every live queue entry with addr X dead in the same cycle. This includes an entry enqueued that cycle with mc_addr=X.
REQ-016 A dead head entry SHALL be popped without a register-file write in any cycle, even while a pipeline write is selected.
REQ-017 pending_a SHALL be 1 iff chk_addr_a!=0 and some live queue entry has that address; pending_b likewise. Both are combinational from queue state only.
REQ-018 stall_cnt SHALL increment on each posedge with mc_valid=1 and mc_ready=0, saturating at 16'hFFFF.
REQ-019 Full queue plus simultaneous pop: mc_ready SHALL remain 0 that cycle; it rises the following cycle.

Reset
REQ-020 While rst=1, the block SHALL hold: rf_we=0, rf_addr=0, rf_data=0, queue empty with all entries dead, mc_ready=0, pending_a=pending_b=0, stall_cnt=0.
REQ-021 Reset asserted mid-operation SHALL discard queued results without any rf write; mc_ready SHALL be 1 from the first clk edge after rst falls.

Structure
REQ-022 Package wb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0 and the queue-entry struct {live, addr, data}.
REQ-023 The queue SHALL be one sub-module, wb_kill_fifo: a DEPTH-entry sync FIFO with a per-entry address-match kill and a match-lookup port.

Verification
REQ-024 mc_valid with addr 5, data 32'hA5A5_0001, empty queue, wb_write=0 -> next cycle rf_we=1, rf_addr=5, rf_data=32'hA5A5_0001 (bypass).
REQ-025 Same edge: wb_write to addr 3 (32'h11) and mc to addr 7 (32'h22) -> cycle+1 writes r3=32'h11, cycle+2 writes r7=32'h22; pending_a=1 for chk_addr_a=7 during cycle+1 only.
REQ-026 DEPTH=2, wb_write held on addr 1 for 4 cycles, mc_valid held -> two mc transfers, then mc_ready=0 and stall_cnt counts 2; after wb_write drops, queue drains in order, one entry per cycle.
REQ-027 Queue holds mc entry for addr 9; pipeline writes r9=32'hBEEF -> only r9=32'hBEEF reaches rf, the queued r9 is never written, and pending for addr 9 clears the next cycle.
REQ-028 mc_addr=0 with mc_valid; later wb_write with wb_addr=0 -> rf_we stays 0 throughout.
REQ-029 Two entries queued, rst pulsed mid-cycle -> all outputs are at reset values immediately, with no rf_we afterwards until new requests arrive.
